vec_unpacker: RTL
=================

VEC_UNPACKER -- requirements
Module: vec_unpacker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the scalar element width in bits.
REQ-002 The block SHALL have parameter LANES, default 6, giving the number of elements per vector.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the upstream word this cycle.
REQ-007 The block SHALL have port in_data, input, LANES*DATA_W bits (192): packed vector; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-008 The block SHALL have port in_scalar, input, 1 bit: the word carries a scalar in lane 0 only.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid element.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the element.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: current element.
REQ-012 The block SHALL have port out_lane, output, clog2(LANES) bits (3): lane index of out_data.
REQ-013 The block SHALL have port out_last, output, 1 bit: out_data is the final element of the current word.

Function
REQ-014 Input transfer SHALL occur on a cycle with in_valid && in_ready; output transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-015 The FSM SHALL have two states: IDLE (no word held) and SEND (word held, elements pending).
REQ-016 in_ready SHALL be 1 in IDLE, 1 in SEND only when an output transfer with out_last=1 occurs in the same cycle, and 0 otherwise.
REQ-017 On an input transfer, the block SHALL register in_data and in_scalar, set the lane counter to 0, and enter SEND; out_valid SHALL rise on the next cycle (1-cycle latency).
REQ-018 In SEND, out_data SHALL equal registered lane[counter], out_lane SHALL equal counter, and out_valid SHALL be 1.
REQ-019 out_last SHALL be 1 when the registered scalar flag is 1 (counter 0), or when counter == LANES-1 for vector words.
REQ-020 On an output transfer with out_last=0, the counter SHALL increment by 1; lanes SHALL be emitted in ascending order 0..LANES-1 with no gaps.
REQ-021 On an output transfer with out_last=1 and no simultaneous input transfer, the block SHALL return to IDLE and drop out_valid on the next cycle.
REQ-022 On an output transfer with out_last=1 and a simultaneous input transfer, the block SHALL load the new word, reset the counter to 0, and remain in SEND, giving back-to-back streaming with no bubble.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_lane and out_last SHALL hold stable.
REQ-024 In IDLE, out_valid and out_last SHALL be 0, out_data SHALL hold 0, and out_lane SHALL hold 0.
REQ-025 A vector word SHALL take exactly LANES output transfers; a scalar word SHALL take exactly 1.
REQ-026 The counter SHALL never exceed LANES-1; no wrap occurs without an out_last transfer.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL enter IDLE, clear the counter, data and scalar registers, and drive out_valid=0, out_last=0, out_lane=0 and out_data=0.
REQ-028 in_ready SHALL be 0 during any cycle in which rst=1.
REQ-029 Reset asserted mid-word SHALL discard the remaining elements; no element of that word SHALL appear after reset deasserts.

Structure
REQ-030 DATA_W, LANES, LANE_IDX_W (clog2 of LANES) and the state enum {IDLE, SEND} SHALL reside in the shared package vec_pkg.
REQ-031 Lane selection SHALL be a combinational sub-module lane_select (LANES-to-1, DATA_W wide) instantiated once; the FSM, counter and registers SHALL reside in vec_unpacker.

Verification
REQ-032 The bench SHALL drive a vector word (lane k = 32'h1000_0000+k) with out_ready held at 1, and check that the element of lane k (32'h1000_0000+k) appears on out_data with out_lane k on 6 consecutive cycles starting 1 cycle after acceptance, with out_last only on lane 5.
REQ-033 The bench SHALL drive a scalar word (in_scalar=1, lane 0 = 32'hF0F0F0F0, other lanes 32'hFFFFFFFF) and check that exactly one element, 32'hF0F0F0F0, is emitted with out_lane 0 and out_last 1.
REQ-034 The bench SHALL hold out_ready=0 for 3 cycles at lane 2 and check that out_data, out_lane and out_last stay stable and in_ready stays 0.
REQ-035 The bench SHALL present two vector words back-to-back with in_valid held at 1 and out_ready held at 1, and check 12 consecutive valid cycles with no bubble and in_ready pulsing only on the lane-5 cycle.
REQ-036 The bench SHALL assert rst for 1 cycle after lane 3 is emitted, and check that out_valid=0 on the next cycle, no lanes 4 or 5 are emitted, and in_ready=1 after rst deasserts.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and default sizing for the vector unpacker.
package vec_pkg;

  localparam int DATA_W     = 32;
  localparam int LANES      = 6;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/lane_select.sv
// Combinational LANES-to-1 element multiplexer over a packed vector.
module lane_select import vec_pkg::*; #(
  parameter int DATA_W = vec_pkg::DATA_W,
  parameter int LANES  = vec_pkg::LANES
) (
  input  logic [LANES*DATA_W-1:0] data,
  input  logic [$clog2(LANES)-1:0] sel,
  output logic [DATA_W-1:0]        elem
);

  localparam int SEL_W = $clog2(LANES);

  always_comb begin
    // NOTE: default assignment first so an out-of-range sel cannot infer a latch.
    elem = '0;
    for (int k = 0; k < LANES; k++) begin
      if (sel == SEL_W'(k)) elem = data[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/vec_unpacker.sv
// Splits a packed LANES-element word (or a lane-0 scalar) into a stream of
// single elements with valid/ready handshakes on both sides.
module vec_unpacker import vec_pkg::*; #(
  parameter int DATA_W = vec_pkg::DATA_W,
  parameter int LANES  = vec_pkg::LANES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  in_data,
  input  logic                     in_scalar,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(LANES)-1:0] out_lane,
  output logic                     out_last
);

  localparam int              IDX_W     = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  state_t                    state;
  logic [IDX_W-1:0]          cnt;
  logic [LANES*DATA_W-1:0]   data_q;
  logic                      scalar_q;
  logic [DATA_W-1:0]         sel_data;
  logic                      in_fire;
  logic                      out_fire;

  lane_select #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_lane_select (
    .data (data_q),
    .sel  (cnt),
    .elem (sel_data)
  );

  assign out_valid = (state == SEND);
  assign out_last  = out_valid && (scalar_q || (cnt == LAST_LANE));
  assign out_lane  = cnt;
  assign out_data  = out_valid ? sel_data : '0;

  // A new word is taken only when nothing is held or the held word's last
  // element leaves this very cycle, which gives bubble-free streaming.
  assign in_ready  = !rst && (!out_valid || (out_ready && out_last));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      // NOTE: the wide data register is cleared on reset as well, so no
      // element of an interrupted word can leak out afterwards.
      data_q   <= '0;
      scalar_q <= 1'b0;
    end else if (in_fire) begin
      data_q   <= in_data;
      scalar_q <= in_scalar;
      cnt      <= '0;
      state    <= SEND;
    end else if (out_fire) begin
      if (out_last) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
